// File: rtl/cpc_vram_scheduler.sv
// 16-phase video RAM time-slot scheduler: CRTC fetches in slots 2/6, one CPU access in slot 10,
// plus the 1 MHz CRTC clock-enable strobes.
module cpc_vram_scheduler #(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic        CLOCK,
    input  logic        nRESET,
    input  logic        CE16,
    output logic [3:0]  phase,
    output logic        crtc_clken,
    output logic        crtc_nclken,
    input  logic [13:0] MA,
    input  logic [4:0]  RA,
    output logic [15:0] vid_data,
    output logic        vid_strobe,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {
        CPU_IDLE,
        CPU_READ,
        CPU_WRITE
    } cpu_state_t;

    localparam logic [3:0] PH_BYTE0  = 4'(2 + RAM_LAT);
    localparam logic [3:0] PH_BYTE1  = 4'(6 + RAM_LAT);
    localparam logic [3:0] PH_CPU_RD = 4'(10 + RAM_LAT);

    cpu_state_t cpu_state;
    logic       served;
    logic [7:0] byte0;
    logic [7:0] byte1;
    logic [7:0] byte1_now;
    logic       unused_addr_bits;

    // With RAM_LAT=2 the second byte arrives on the same tick that publishes vid_data.
    assign byte1_now = (RAM_LAT == 2) ? ram_dout : byte1;

    assign crtc_clken  = nRESET & CE16 & (phase == 4'd15);
    assign crtc_nclken = nRESET & CE16 & (phase == 4'd7);
    assign cpu_wait    = nRESET & cpu_req & ~served & ~cpu_ack;

    assign unused_addr_bits = ^{MA[11:10], RA[4:3]};

    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            phase      <= '0;
            vid_data   <= '0;
            vid_strobe <= 1'b0;
            cpu_dout   <= '0;
            cpu_ack    <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            ram_we     <= 1'b0;
            ram_din    <= '0;
            byte0      <= '0;
            byte1      <= '0;
            served     <= 1'b0;
            cpu_state  <= CPU_IDLE;
        end else begin
            vid_strobe <= 1'b0;
            cpu_ack    <= 1'b0;
            ram_rd     <= 1'b0;
            ram_we     <= 1'b0;

            if (!cpu_req) begin
                served <= 1'b0;
            end

            if (CE16) begin
                phase <= phase + 4'd1;

                // Strobes are set one tick early so they land in the slot itself.
                case (phase)
                    4'd1: begin
                        ram_rd   <= 1'b1;
                        ram_addr <= {MA[13:12], RA[2:0], MA[9:0], 1'b0};
                    end
                    4'd5: begin
                        ram_rd   <= 1'b1;
                        ram_addr <= {MA[13:12], RA[2:0], MA[9:0], 1'b1};
                    end
                    4'd9: begin
                        if (cpu_req && !served) begin
                            ram_addr  <= cpu_addr;
                            ram_we    <= cpu_we;
                            ram_rd    <= ~cpu_we;
                            ram_din   <= cpu_din;
                            cpu_state <= cpu_we ? CPU_WRITE : CPU_READ;
                        end
                    end
                    default: ;
                endcase

                if (phase == PH_BYTE0) begin
                    byte0 <= ram_dout;
                end
                if (phase == PH_BYTE1) begin
                    byte1 <= ram_dout;
                end
                if (phase == 4'd8) begin
                    vid_data   <= {byte0, byte1_now};
                    vid_strobe <= 1'b1;
                end

                if (phase == PH_CPU_RD && cpu_state == CPU_READ) begin
                    cpu_dout <= ram_dout;
                end
                if (phase == 4'd12 && cpu_state != CPU_IDLE) begin
                    cpu_ack   <= 1'b1;
                    served    <= 1'b1;
                    cpu_state <= CPU_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpc_vram_scheduler.sv
// Self-checking bench for cpc_vram_scheduler: per-cycle slot-level reference model, table of
// video fetch vectors, directed CPU/reset sequences and a randomized run.
module tb_cpc_vram_scheduler;

    logic        CLOCK = 1'b0;
    logic        nRESET = 1'b0;
    logic        CE16 = 1'b0;
    logic [3:0]  phase;
    logic        crtc_clken, crtc_nclken;
    logic [13:0] MA = '0;
    logic [4:0]  RA = '0;
    logic [15:0] vid_data;
    logic        vid_strobe;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack, cpu_wait;
    logic [15:0] ram_addr;
    logic        ram_rd, ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;

    always #5 CLOCK = ~CLOCK;

    cpc_vram_scheduler #(.RAM_LAT(2)) u_dut (
        .CLOCK(CLOCK), .nRESET(nRESET), .CE16(CE16), .phase(phase),
        .crtc_clken(crtc_clken), .crtc_nclken(crtc_nclken), .MA(MA), .RA(RA),
        .vid_data(vid_data), .vid_strobe(vid_strobe), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .cpu_wait(cpu_wait), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_we(ram_we),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mem [0:65535];

    // Reference model state: slot number = CE16 ticks since reset, mod 16.
    int         m_phase = 0;
    bit         m_served = 0;
    bit         m_inflight = 0;
    bit         m_gwe = 0;
    bit         m_ack = 0;
    logic [7:0] m_gdata = '0;
    logic [7:0] m_b0 = '0;
    logic [7:0] m_b1 = '0;
    logic [7:0] m_cpu_dout = '0;
    logic [15:0] m_vid = '0;

    int clk_pulses = 0, clk_badph = 0, nclk_pulses = 0, nclk_badph = 0;

    typedef struct {
        logic [13:0] ma;
        logic [4:0]  ra;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          a0;
        int          a1;
        int          vid;
    } vvec_t;

    vvec_t vt [5];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] vaddr(input logic [13:0] ma, input logic [4:0] ra, input int b);
        int a;
        a = ((int'(ma) / 4096) % 4) * 16384 + (int'(ra) % 8) * 2048 + (int'(ma) % 1024) * 2 + b;
        return a[15:0];
    endfunction

    task automatic step();
        logic prst, pce, preq, pwe;
        logic [15:0] paddr;
        logic [7:0]  pdin;
        logic [13:0] pma;
        logic [4:0]  pra;
        logic exp_rd, exp_we, exp_vs;
        logic [15:0] exp_addr;
        logic [7:0]  exp_din;

        @(negedge CLOCK);
        chk("crtc_clken", int'(crtc_clken), int'(nRESET && CE16 && (m_phase == 15)));
        chk("crtc_nclken", int'(crtc_nclken), int'(nRESET && CE16 && (m_phase == 7)));
        chk("cpu_wait", int'(cpu_wait), int'(nRESET && cpu_req && !m_served && !m_ack));
        if (crtc_clken) begin
            clk_pulses++;
            if (phase != 4'd15) clk_badph++;
        end
        if (crtc_nclken) begin
            nclk_pulses++;
            if (phase != 4'd7) nclk_badph++;
        end
        prst = nRESET; pce = CE16; preq = cpu_req; pwe = cpu_we;
        paddr = cpu_addr; pdin = cpu_din; pma = MA; pra = RA;

        @(posedge CLOCK);
        #1;
        exp_rd = 0; exp_we = 0; exp_vs = 0; exp_addr = '0; exp_din = '0;
        m_ack = 0;
        if (!prst) begin
            m_phase = 0; m_served = 0; m_inflight = 0;
            m_vid = '0; m_cpu_dout = '0;
        end else begin
            if (!preq) m_served = 0;
            if (pce) begin
                m_phase = (m_phase + 1) % 16;
                if (m_phase == 2 || m_phase == 6) begin
                    exp_rd = 1;
                    exp_addr = vaddr(pma, pra, (m_phase == 6) ? 1 : 0);
                    if (m_phase == 2) m_b0 = mem[exp_addr];
                    else m_b1 = mem[exp_addr];
                end
                if (m_phase == 9) begin
                    exp_vs = 1;
                    m_vid = {m_b0, m_b1};
                end
                if (m_phase == 10 && preq && !m_served) begin
                    m_inflight = 1;
                    m_gwe = pwe;
                    exp_addr = paddr;
                    exp_we = pwe;
                    exp_rd = !pwe;
                    exp_din = pdin;
                    m_gdata = mem[paddr];
                end
                if (m_phase == 13 && m_inflight) begin
                    m_ack = 1;
                    m_served = 1;
                    m_inflight = 0;
                    if (!m_gwe) m_cpu_dout = m_gdata;
                end
            end
        end

        chk("phase", int'(phase), m_phase);
        chk("ram_rd", int'(ram_rd), int'(exp_rd));
        chk("ram_we", int'(ram_we), int'(exp_we));
        chk("vid_strobe", int'(vid_strobe), int'(exp_vs));
        chk("cpu_ack", int'(cpu_ack), int'(m_ack));
        chk("vid_data", int'(vid_data), int'(m_vid));
        chk("cpu_dout", int'(cpu_dout), int'(m_cpu_dout));
        if (exp_rd || exp_we) chk("ram_addr", int'(ram_addr), int'(exp_addr));
        if (exp_we) chk("ram_din", int'(ram_din), int'(exp_din));
        if (!prst) begin
            chk("rst_ram_addr", int'(ram_addr), 0);
            chk("rst_ram_din", int'(ram_din), 0);
        end

        // Behavioural RAM: zero-latency, output held until the next read.
        if (ram_we) mem[ram_addr] = ram_din;
        else if (ram_rd) ram_dout = mem[ram_addr];
    endtask

    task automatic run_to_phase(input int p);
        for (int k = 0; k < 40 && m_phase != p; k++) step();
        chk("sync_phase", int'(phase), p);
    endtask

    initial begin
        int got, lat, wgap, acc, acc_at, waits, acks, v2, rq_state, rq_cnt;
        logic [7:0]  dout_at_ack;
        logic [15:0] s10_addr, cap_a0, cap_a1, cap_vid;
        logic [7:0]  s10_din;
        logic        s10_we, cap_vs;

        vt[0] = '{ma: 14'h3000, ra: 5'd5,    d0: 8'h12, d1: 8'h34, a0: 'hE800, a1: 'hE801, vid: 'h1234};
        vt[1] = '{ma: 14'h0000, ra: 5'd0,    d0: 8'hFF, d1: 8'h00, a0: 'h0000, a1: 'h0001, vid: 'hFF00};
        vt[2] = '{ma: 14'h3FFF, ra: 5'd7,    d0: 8'h81, d1: 8'h7E, a0: 'hFFFE, a1: 'hFFFF, vid: 'h817E};
        vt[3] = '{ma: 14'h0C05, ra: 5'h1A,   d0: 8'hC3, d1: 8'h3C, a0: 'h100A, a1: 'h100B, vid: 'hC33C};
        vt[4] = '{ma: 14'h1155, ra: 5'd3,    d0: 8'h5A, d1: 8'hA5, a0: 'h5AAA, a1: 'h5AAB, vid: 'h5AA5};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset, with CE16 running to show reset dominates.
        nRESET = 1'b0; CE16 = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("reset_phase", int'(phase), 0);
        chk("reset_strobes", int'({ram_rd, ram_we, vid_strobe, cpu_ack, cpu_wait}), 0);
        nRESET = 1'b1;

        // CRTC strobe count over 160 ticks.
        clk_pulses = 0; clk_badph = 0; nclk_pulses = 0; nclk_badph = 0;
        for (int i = 0; i < 160; i++) step();
        chk("clken_count", clk_pulses, 10);
        chk("clken_phase", clk_badph, 0);
        chk("nclken_count", nclk_pulses, 10);
        chk("nclken_phase", nclk_badph, 0);

        // Video fetch table.
        for (int i = 0; i < 5; i++) begin
            run_to_phase(0);
            MA = vt[i].ma; RA = vt[i].ra;
            mem[vt[i].a0] = vt[i].d0;
            mem[vt[i].a1] = vt[i].d1;
            cap_a0 = '0; cap_a1 = '0; cap_vid = '0; cap_vs = 1'b0;
            for (int k = 0; k < 16; k++) begin
                step();
                if (m_phase == 2) cap_a0 = ram_addr;
                if (m_phase == 6) cap_a1 = ram_addr;
                if (m_phase == 9) begin cap_vid = vid_data; cap_vs = vid_strobe; end
            end
            chk("tbl_addr0", int'(cap_a0), vt[i].a0);
            chk("tbl_addr1", int'(cap_a1), vt[i].a1);
            chk("tbl_vid", int'(cap_vid), vt[i].vid);
            chk("tbl_strobe", int'(cap_vs), 1);
        end

        // CPU write raised at phase 4.
        run_to_phase(4);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_din = 8'hA5;
        got = 0; lat = 0; wgap = 0; s10_we = 1'b0; s10_addr = '0; s10_din = '0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            step();
            if (m_phase == 10) begin s10_we = ram_we; s10_addr = ram_addr; s10_din = ram_din; end
            if (cpu_ack) begin got = 1; lat = k; end
            else if (!cpu_wait) wgap++;
        end
        chk("wr_ack_seen", got, 1);
        chk("wr_ack_latency", lat, 9);
        chk("wr_slot10_we", int'(s10_we), 1);
        chk("wr_slot10_addr", int'(s10_addr), 'h4000);
        chk("wr_slot10_din", int'(s10_din), 'hA5);
        chk("wr_wait_gap", wgap, 0);
        chk("wr_mem", int'(mem[16'h4000]), 'hA5);
        cpu_req = 1'b0;
        step();

        // CPU read raised one cycle after the phase-9 tick.
        mem[16'h8123] = 8'h5A;
        run_to_phase(10);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8123;
        got = 0; lat = 0; acc = 0; acc_at = 0; dout_at_ack = '0; s10_addr = '0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            step();
            if (m_phase == 10 && (ram_rd || ram_we)) begin acc++; acc_at = k; s10_addr = ram_addr; end
            if (cpu_ack) begin got = 1; lat = k; dout_at_ack = cpu_dout; end
        end
        chk("rd_access_count", acc, 1);
        chk("rd_access_step", acc_at, 16);
        chk("rd_access_addr", int'(s10_addr), 'h8123);
        chk("rd_ack_latency", lat, 19);
        chk("rd_dout", int'(dout_at_ack), 'h5A);

        // Held request for 3 microseconds after ack.
        acc = 0; waits = 0; acks = 0;
        for (int k = 0; k < 48; k++) begin
            step();
            if (m_phase == 10 && (ram_rd || ram_we)) acc++;
            if (cpu_wait) waits++;
            if (cpu_ack) acks++;
        end
        chk("held_access", acc, 0);
        chk("held_wait", waits, 0);
        chk("held_acks", acks, 0);
        cpu_req = 1'b0;
        step();
        cpu_req = 1'b1;
        got = 0; lat = 0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            step();
            if (cpu_ack) begin got = 1; lat = k; end
        end
        chk("reraise_ack", got, 1);
        chk("reraise_latency", lat, 15);
        cpu_req = 1'b0;
        step();

        // Reset with a read grant in flight.
        run_to_phase(5);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2222;
        run_to_phase(11);
        nRESET = 1'b0; cpu_req = 1'b0;
        acks = 0; v2 = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (cpu_ack) acks++;
        end
        chk("midrst_phase", int'(phase), 0);
        chk("midrst_strobes", int'({ram_rd, ram_we, vid_strobe, cpu_ack}), 0);
        nRESET = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            if (cpu_ack) acks++;
            if (m_phase == 2 && ram_rd) v2++;
        end
        chk("midrst_acks", acks, 0);
        chk("midrst_video_resume", v2, 2);

        // Randomized CE16 gaps, CRTC addresses and CPU traffic.
        rq_state = 0; rq_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            CE16 = ($urandom_range(0, 3) != 0);
            if (m_phase == 0) begin
                MA = 14'($urandom);
                RA = 5'($urandom);
            end
            case (rq_state)
                0: if ($urandom_range(0, 7) == 0) begin
                    cpu_req = 1'b1;
                    cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 16'($urandom);
                    cpu_din = 8'($urandom);
                    rq_state = 1;
                end
                1: if (m_ack) begin
                    rq_cnt = int'($urandom_range(0, 40));
                    rq_state = 2;
                end
                2: if (rq_cnt == 0) begin
                    cpu_req = 1'b0;
                    rq_cnt = int'($urandom_range(1, 3));
                    rq_state = 3;
                end else begin
                    rq_cnt--;
                end
                default: if (rq_cnt <= 1) rq_state = 0; else rq_cnt--;
            endcase
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpc_vram_scheduler.md
Name: cpc_vram_scheduler

Overview:
Time-slot scheduler that shares the single 8-bit video RAM between CRTC display fetches and Z80 CPU accesses on a fixed 16-phase microsecond cycle. It also generates the 1 MHz CLKEN/nCLKEN strobes that advance the CRTC, so MA/RA are stable throughout each fetch window. It sits between the CRTC, the CPU bus interface and the SDRAM/BRAM port, and feeds 16-bit fetched pixel words to the gate-array pixel serialiser.

Parameters:
RAM_LAT, 2, number of CE16 ticks from the RAM read strobe to valid ram_dout; legal values are 1 or 2.

Ports:
CLOCK  in  1  system clock
nRESET  in  1  synchronous, active-low reset
CE16  in  1  16 MHz tick enable; all sequencing advances only on CE16
phase  out  4  current slot phase, 0..15
crtc_clken  out  1  CRTC CLKEN strobe
crtc_nclken  out  1  CRTC nCLKEN strobe
MA  in  14  CRTC memory address
RA  in  5  CRTC row address
vid_data  out  16  fetched word: {byte0, byte1}
vid_strobe  out  1  vid_data updated
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  16  CPU RAM address
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data
cpu_ack  out  1  access complete
cpu_wait  out  1  stall to the CPU
ram_addr  out  16  RAM address
ram_rd  out  1  RAM read strobe
ram_we  out  1  RAM write strobe
ram_din  out  8  RAM write data
ram_dout  in  8  RAM read data

Behaviour:
- Reset is synchronous and active-low on CLOCK. During and after reset:
  - phase = 0.
  - All strobes are 0: crtc_clken, crtc_nclken, vid_strobe, cpu_ack, ram_rd, ram_we.
  - vid_data = 0, cpu_dout = 0, ram_addr = 0, ram_din = 0, cpu_wait = 0.
  - The served flag is cleared and any grant in flight is cancelled. No ack is issued for a cancelled grant.
- Phase counter: increments modulo 16 on each CE16 tick. Without CE16, all state holds.
- CRTC strobes (combinational, single cycle):
  - crtc_clken = CE16 & (phase == 15), so the CRTC advances at the 15->0 wrap.
  - crtc_nclken = CE16 & (phase == 7).
- Slot timing convention: "slot P" means the single CLOCK cycle immediately after the CE16 tick that sets phase to P. ram_rd, ram_we, ram_addr and ram_din are registered and meaningful only during slots. ram_rd and ram_we are never both 1.
- Video slots (every microsecond, unconditional, independent of DE):
  - Slot 2: ram_rd = 1, ram_addr = {MA[13:12], RA[2:0], MA[9:0], 1'b0}.
  - Slot 6: ram_rd = 1, ram_addr = {MA[13:12], RA[2:0], MA[9:0], 1'b1}.
  - ram_dout is captured on the CE16 tick with phase == 2+RAM_LAT (byte0 -> vid_data[15:8]) and phase == 6+RAM_LAT (byte1 -> vid_data[7:0]).
  - vid_strobe: 1-cycle pulse in slot 9. vid_data is stable from slot 9 through slot 8 of the next microsecond.
- CPU slot:
  - cpu_req is sampled on the CE16 tick with phase == 9. Grant if cpu_req = 1 and served = 0.
  - Granted, slot 10: ram_addr = cpu_addr; ram_we = cpu_we; ram_rd = ~cpu_we; ram_din = cpu_din.
  - Read data: ram_dout is captured into cpu_dout on the tick with phase == 10+RAM_LAT. On writes cpu_dout holds its previous value.
  - cpu_ack: 1-cycle pulse in slot 13. served is set at the same time.
  - served clears on any cycle where cpu_req = 0. A new access therefore requires cpu_req to be low for at least 1 CLOCK cycle; a held request is never served twice.
  - cpu_wait = cpu_req & ~served & ~cpu_ack (combinational).
- Request-edge cases:
  - A request asserted on the phase-9 tick is granted that microsecond.
  - A request asserted on any later cycle waits for the next phase-9 sample.
  - Worst-case latency is 16 phases + 4.
- Phases 0, 1, 3–5, 7–9 and 11–15 carry no RAM strobe, except that slot 10 is empty when no grant is made.
- Video slots have absolute priority; the CPU can never displace a video fetch.

Test Plan:
- Reset mid-grant (nRESET low at phase 11 with a read in flight) -> phase = 0, no cpu_ack, all strobes 0; normal slots resume after release.
- CE16 continuous, MA = 0x3000, RA = 5 -> slot 2 ram_addr = 0xE800, slot 6 = 0xE801; ram_dout 0x12 then 0x34 -> vid_data = 0x1234 with vid_strobe in slot 9.
- crtc_clken count over 160 CE16 ticks -> exactly 10 pulses, each at phase 15; crtc_nclken 10 pulses, each at phase 7.
- CPU write: cpu_req at phase 4, addr 0x4000, din 0xA5 -> slot 10 ram_we = 1, ram_addr = 0x4000, ram_din = 0xA5; cpu_ack in slot 13; cpu_wait high from request to ack.
- CPU read: request raised 1 cycle after the phase-9 tick -> no slot-10 access that microsecond; read in the next slot 10; cpu_dout = ram_dout (0x5A) at ack; exactly 1 ack.
- Held request: cpu_req kept high 3 microseconds after ack -> no further RAM access, cpu_wait = 0; drop then re-raise -> served next microsecond.
